// File: rtl/ysyx_22040759_redirect_ctrl.sv
// ysyx_22040759_redirect_ctrl: sequences branch/trap redirects: flush IF/ID, drain in-flight fetches, hand new PC to fetch
module ysyx_22040759_redirect_ctrl #(
  parameter int XLEN = 64,
  parameter int MAX_OS = 2,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_br_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            if_req_fire,
  input  logic            if_rsp_valid,
  input  logic            if_redirect_ready,
  output logic            if_req_allow,
  output logic            drop_rsp,
  output logic            flush_if,
  output logic            flush_id,
  output logic            stall_ex,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     redirect_cnt
);
  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] os_cnt, os_nxt;
  logic [XLEN-1:0] pc_q;
  logic br_ev, ev, cap, done;
  always_comb begin
    stall_ex = state != IDLE;
    br_ev = ex_valid & ex_br_taken & ~stall_ex;
    ev = trap_valid | br_ev;
    cap = (state == IDLE) & ev;
    os_nxt = (if_req_fire & ~if_rsp_valid & (os_cnt != CNT_W'(MAX_OS))) ? os_cnt + 1'b1 :
             (if_rsp_valid & ~if_req_fire & (os_cnt != '0)) ? os_cnt - 1'b1 : os_cnt;
    if_req_allow = (state == IDLE) & ~ev & (os_cnt < CNT_W'(MAX_OS));
    flush_if = cap | (state == DRAIN);
    flush_id = flush_if;
    drop_rsp = flush_if & if_rsp_valid;
    redirect_valid = (state == ISSUE) & ~trap_valid;
    redirect_pc = pc_q;
    done = redirect_valid & if_redirect_ready;
    state_nxt = state;
    if (cap) state_nxt = (os_nxt == '0) ? ISSUE : DRAIN;
    if ((state == DRAIN) && (os_nxt == '0)) state_nxt = ISSUE;
    if (done) state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      os_cnt <= '0;
      pc_q <= '0;
      redirect_cnt <= '0;
    end else begin
      state <= state_nxt;
      os_cnt <= os_nxt;
      pc_q <= trap_valid ? trap_pc : br_ev ? ex_br_pc : pc_q;
      redirect_cnt <= redirect_cnt + {31'b0, done};
    end
  end
endmodule

// File: tb/tb_ysyx_22040759_redirect_ctrl.sv
// tb_ysyx_22040759_redirect_ctrl: directed self-checking bench for the redirect sequencer
module tb_ysyx_22040759_redirect_ctrl;
  logic clk = 0, rst = 1;
  logic ex_valid = 0, ex_br_taken = 0, trap_valid = 0;
  logic if_req_fire = 0, if_rsp_valid = 0, if_redirect_ready = 0;
  logic [63:0] ex_br_pc = '0, trap_pc = '0;
  logic if_req_allow, drop_rsp, flush_if, flush_id, stall_ex, redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] redirect_cnt;
  logic [5:0] ctl;
  int chk = 0, err = 0;
  ysyx_22040759_redirect_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_br_taken(ex_br_taken), .ex_br_pc(ex_br_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .if_req_fire(if_req_fire), .if_rsp_valid(if_rsp_valid),
    .if_redirect_ready(if_redirect_ready), .if_req_allow(if_req_allow), .drop_rsp(drop_rsp),
    .flush_if(flush_if), .flush_id(flush_id), .stall_ex(stall_ex), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_cnt(redirect_cnt)
  );
  assign ctl = {flush_if, flush_id, drop_rsp, stall_ex, redirect_valid, if_req_allow};
  always #5 clk = ~clk;
  task cyc();
    @(posedge clk);
    @(negedge clk);
    ex_valid = 0; ex_br_taken = 0; trap_valid = 0; if_req_fire = 0; if_rsp_valid = 0;
  endtask
  task branch(input logic [63:0] pc);
    ex_valid = 1; ex_br_taken = 1; ex_br_pc = pc;
  endtask
  task test_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk++; if (ctl !== 6'b000001) begin err++; $display("FAIL reset_ctl got %b exp %b", ctl, 6'b000001); end
    chk++; if (redirect_pc !== 64'h0) begin err++; $display("FAIL reset_pc got %h exp %h", redirect_pc, 64'h0); end
    chk++; if (redirect_cnt !== 32'h0) begin err++; $display("FAIL reset_cnt got %h exp %h", redirect_cnt, 32'h0); end
    cyc();
  endtask
  task test_branch_idle();
    if_redirect_ready = 1; branch(64'h8000_0100); #1;
    chk++; if (ctl !== 6'b110000) begin err++; $display("FAIL br_cap_ctl got %b exp %b", ctl, 6'b110000); end
    cyc(); #1;
    chk++; if (ctl !== 6'b000110) begin err++; $display("FAIL br_issue_ctl got %b exp %b", ctl, 6'b000110); end
    chk++; if (redirect_pc !== 64'h8000_0100) begin err++; $display("FAIL br_pc got %h exp %h", redirect_pc, 64'h8000_0100); end
    cyc(); #1;
    chk++; if (ctl !== 6'b000001) begin err++; $display("FAIL br_idle_ctl got %b exp %b", ctl, 6'b000001); end
    chk++; if (redirect_cnt !== 32'd1) begin err++; $display("FAIL br_cnt got %0d exp %0d", redirect_cnt, 1); end
  endtask
  task test_drain_two();
    logic [5:0] exp [7] = '{6'b110000, 6'b110100, 6'b111100, 6'b110100, 6'b111100, 6'b000110, 6'b000001};
    cyc(); if_req_fire = 1; #1;
    chk++; if (ctl !== 6'b000001) begin err++; $display("FAIL dr_fire0 got %b exp %b", ctl, 6'b000001); end
    cyc(); if_req_fire = 1;
    cyc(); #1;
    chk++; if (ctl !== 6'b000000) begin err++; $display("FAIL dr_full got %b exp %b", ctl, 6'b000000); end
    cyc(); branch(64'h8000_0200);
    for (int i = 0; i < 7; i++) begin
      if (i == 2 || i == 4) if_rsp_valid = 1;
      #1;
      chk++; if (ctl !== exp[i]) begin err++; $display("FAIL dr_T+%0d got %b exp %b", i, ctl, exp[i]); end
      if (i == 5) begin
        chk++; if (redirect_pc !== 64'h8000_0200) begin err++; $display("FAIL dr_pc got %h exp %h", redirect_pc, 64'h8000_0200); end
      end
      cyc();
    end
    chk++; if (redirect_cnt !== 32'd2) begin err++; $display("FAIL dr_cnt got %0d exp %0d", redirect_cnt, 2); end
  endtask
  task test_collision();
    if_req_fire = 1;
    cyc(); branch(64'h8000_0300); if_rsp_valid = 1; #1;
    chk++; if (ctl !== 6'b111000) begin err++; $display("FAIL col_cap got %b exp %b", ctl, 6'b111000); end
    cyc(); #1;
    chk++; if (ctl !== 6'b000110) begin err++; $display("FAIL col_issue got %b exp %b", ctl, 6'b000110); end
    chk++; if (redirect_pc !== 64'h8000_0300) begin err++; $display("FAIL col_pc got %h exp %h", redirect_pc, 64'h8000_0300); end
    cyc(); branch(64'h8000_0380); if_req_fire = 1; #1;
    chk++; if (ctl !== 6'b110000) begin err++; $display("FAIL colf_cap got %b exp %b", ctl, 6'b110000); end
    cyc(); if_rsp_valid = 1; #1;
    chk++; if (ctl !== 6'b111100) begin err++; $display("FAIL colf_drop got %b exp %b", ctl, 6'b111100); end
    cyc(); #1;
    chk++; if (ctl !== 6'b000110 || redirect_pc !== 64'h8000_0380) begin err++; $display("FAIL colf_issue got %b/%h exp %b/%h", ctl, redirect_pc, 6'b000110, 64'h8000_0380); end
    cyc(); #1;
    chk++; if (redirect_cnt !== 32'd4) begin err++; $display("FAIL col_cnt got %0d exp %0d", redirect_cnt, 4); end
  endtask
  task test_trap();
    trap_valid = 1; trap_pc = 64'h8000_0000; branch(64'h8000_0400); #1;
    chk++; if (ctl !== 6'b110000) begin err++; $display("FAIL tr_cap got %b exp %b", ctl, 6'b110000); end
    cyc(); trap_valid = 1; trap_pc = 64'h8000_0004; #1;
    chk++; if (ctl !== 6'b000100) begin err++; $display("FAIL tr_override got %b exp %b", ctl, 6'b000100); end
    chk++; if (redirect_pc !== 64'h8000_0000) begin err++; $display("FAIL tr_prio_pc got %h exp %h", redirect_pc, 64'h8000_0000); end
    cyc(); #1;
    chk++; if (ctl !== 6'b000110 || redirect_pc !== 64'h8000_0004) begin err++; $display("FAIL tr_issue got %b/%h exp %b/%h", ctl, redirect_pc, 6'b000110, 64'h8000_0004); end
    cyc(); #1;
    chk++; if (ctl !== 6'b000001 || redirect_cnt !== 32'd5) begin err++; $display("FAIL tr_done got %b/%0d exp %b/%0d", ctl, redirect_cnt, 6'b000001, 5); end
  endtask
  task test_backpressure_reset();
    if_redirect_ready = 0; branch(64'h8000_0500);
    cyc(); branch(64'h8000_dead);
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk++; if (ctl !== 6'b000110 || redirect_pc !== 64'h8000_0500) begin err++; $display("FAIL bp_T+%0d got %b/%h exp %b/%h", i, ctl, redirect_pc, 6'b000110, 64'h8000_0500); end
      if (i < 3) cyc();
    end
    #2 rst = 1; #1;
    chk++; if (ctl !== 6'b000001 || redirect_pc !== 64'h0 || redirect_cnt !== 32'h0) begin err++; $display("FAIL rst_mid got %b/%h/%0d exp %b/0/0", ctl, redirect_pc, redirect_cnt, 6'b000001); end
    cyc(); rst = 0; #1;
    chk++; if (ctl !== 6'b000001 || redirect_cnt !== 32'h0) begin err++; $display("FAIL rst_rel got %b/%0d exp %b/0", ctl, redirect_cnt, 6'b000001); end
    cyc();
  endtask
  task test_os_bounds();
    if_rsp_valid = 1;
    cyc(); #1;
    chk++; if (ctl !== 6'b000001) begin err++; $display("FAIL os_under got %b exp %b", ctl, 6'b000001); end
    if_req_fire = 1;
    cyc(); if_req_fire = 1;
    cyc(); if_req_fire = 1; #1;
    chk++; if (ctl !== 6'b000000) begin err++; $display("FAIL os_full got %b exp %b", ctl, 6'b000000); end
    cyc(); if_rsp_valid = 1;
    cyc(); #1;
    chk++; if (ctl !== 6'b000001) begin err++; $display("FAIL os_over got %b exp %b", ctl, 6'b000001); end
    if_rsp_valid = 1;
    cyc();
  endtask
  task test_wrap();
    force dut.redirect_cnt = 32'hFFFF_FFFF;
    #1 release dut.redirect_cnt;
    #1;
    chk++; if (redirect_cnt !== 32'hFFFF_FFFF) begin err++; $display("FAIL wr_preload got %h exp %h", redirect_cnt, 32'hFFFF_FFFF); end
    if_redirect_ready = 1; branch(64'h8000_0600);
    cyc(); #1;
    chk++; if (ctl !== 6'b000110 || redirect_pc !== 64'h8000_0600) begin err++; $display("FAIL wr_issue got %b/%h exp %b/%h", ctl, redirect_pc, 6'b000110, 64'h8000_0600); end
    cyc(); #1;
    chk++; if (redirect_cnt !== 32'h0) begin err++; $display("FAIL wr_cnt got %h exp %h", redirect_cnt, 32'h0); end
  endtask
  initial begin
    test_reset();
    test_branch_idle();
    test_drain_two();
    test_collision();
    test_trap();
    test_backpressure_reset();
    test_os_bounds();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
